sum_overflow_monitor: RTL
=========================

Name: sum_overflow_monitor

Overview:
- Downstream consumer of the 16-bit unsigned accumulator (sum, overflow_flag outputs) in the same clock domain.
- Samples sum and overflow every cycle, measures each accumulation epoch, and turns each overflow event into a record.
- Records are {wrapped residual, epoch length}, queued in a small first-word-fall-through FIFO and delivered over a valid/ready handshake.
- Also keeps a saturating overflow-event counter and a sticky drop flag for software/debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- LEN_W, 16, width of the epoch-length counter and record field.
- LVL_W, 3, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- sum_in  input  16  accumulator sum output, unsigned.
- overflow_in  input  1  accumulator overflow flag.
- drop_clr  input  1  synchronous clear of drop_flag.
- rec_valid  output  1  head record available.
- rec_ready  input  1  consumer accepts head record.
- rec_residual  output  16  sum_in captured in the overflow cycle.
- rec_length  output  LEN_W  non-overflow cycles preceding the event.
- event_count  output  16  total overflow cycles seen, saturating.
- drop_flag  output  1  sticky: an event was lost because the FIFO was full.
- fifo_level  output  LVL_W  entries currently held, 0..DEPTH.

Behaviour:
- Reset (RST=0, asynchronous):
  - rec_valid=0; rec_residual=0; rec_length=0; event_count=0; drop_flag=0; fifo_level=0.
  - Length counter=0; FIFO pointers=0.
  - Reset mid-operation discards all queued records immediately.
- Length counter, per edge:
  - overflow_in=0: counter <= counter+1, saturating at 2^LEN_W-1.
  - overflow_in=1: counter <= 0; the pre-edge counter value is the event's length.
- Event: any cycle with overflow_in=1, level-sensitive, no edge detection.
  - Back-to-back overflow cycles are separate events; the second has length 0.
  - Record = {sum_in, counter} as sampled on that edge.
- FIFO push/pop:
  - pop = rec_valid & rec_ready.
  - push accepted if fifo_level<DEPTH, or if fifo_level==DEPTH and pop is true in the same cycle.
  - Otherwise the event is dropped: drop_flag <= 1, and the FIFO is unchanged.
- Latency: an event sampled at edge N gives rec_valid=1 from edge N onward (visible in cycle N+1) if the FIFO was empty.
  - Same-cycle bypass from sum_in to the outputs is not permitted.
- Output data:
  - rec_valid = (fifo_level!=0).
  - rec_residual and rec_length always show the head entry (first-word fall-through).
  - Outputs must hold stable while rec_valid=1 and rec_ready=0.
  - With the FIFO empty, rec_residual and rec_length hold their last values, or 0 after reset.
- fifo_level:
  - +1 on push only; -1 on pop only; unchanged on push+pop or on neither.
  - Pointers wrap modulo DEPTH.
- event_count: +1 on every event, including dropped ones; saturates at 0xFFFF.
- drop_flag:
  - drop_clr=1 clears it, except in a cycle that also drops, where set wins.
  - Otherwise sticky until reset.
- rec_ready while rec_valid=0 has no effect.

Test Plan:
- Reset, then overflow_in=0 for 257 cycles, then one cycle with overflow_in=1 and sum_in=0x00FE -> next cycle rec_valid=1, rec_residual=0x00FE, rec_length=257, event_count=1, fifo_level=1.
- Same event with rec_ready=0 for 10 cycles, then rec_ready=1 for 1 cycle -> record stable for all 10 cycles; after the pop, rec_valid=0 and fifo_level=0.
- rec_ready=0; 5 events with sum_in=1..5, 3 idle cycles between each -> fifo_level=4; drop_flag=1 after the 5th; event_count=5; pops return residuals 1,2,3,4 in order, each with length 3 except the first.
- FIFO full, and an event arrives in the same cycle as rec_ready=1 -> push accepted, fifo_level stays 4, drop_flag stays 0; the new record is last out.
- Two consecutive overflow cycles (sum_in=0x0010, then 0x0020) after 7 idle cycles -> records {0x0010,7} then {0x0020,0}.
- RST pulsed low mid-stream with 3 records queued -> all outputs 0 asynchronously; after release, the next event's length counts from reset.

Source files
------------

// File: rtl/sum_overflow_monitor.sv
// Watches a 16-bit accumulator, turns each overflow cycle into a {residual, epoch length}
// record and delivers the records through a small first-word-fall-through FIFO.
module sum_overflow_monitor #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16,
  parameter int LVL_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      sum_in,
  input  logic             overflow_in,
  input  logic             drop_clr,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_residual,
  output logic [LEN_W-1:0] rec_length,
  output logic [15:0]      event_count,
  output logic             drop_flag,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // Handshake: a record transfers on every rising edge where rec_valid and rec_ready are
  // both high; rec_valid never depends on rec_ready, and the head record stays stable
  // while rec_valid is high and rec_ready is low.

  logic [LEN_W-1:0] len_cnt;
  logic [15:0]      res_mem [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign rec_valid  = (fifo_level != '0);
  assign full       = (fifo_level == LVL_W'(DEPTH));
  assign pop        = rec_valid & rec_ready;
  assign push       = overflow_in & (~full | pop);
  assign drop       = overflow_in & ~push;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_cnt <= '0;
    end else if (overflow_in) begin
      len_cnt <= '0;
    end else if (len_cnt != LEN_MAX) begin
      len_cnt <= len_cnt + LEN_W'(1);
    end
  end

  // Storage needs no reset: nothing is read from a slot before it has been written.
  always_ff @(posedge CLK) begin
    if (push) begin
      res_mem[wr_ptr] <= sum_in;
      len_mem[wr_ptr] <= len_cnt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Head registers load whatever becomes the head after this edge, and otherwise hold,
  // so an empty FIFO keeps showing the last delivered record.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rec_residual <= '0;
      rec_length   <= '0;
    end else if (push && (fifo_level == '0 || (pop && fifo_level == LVL_W'(1)))) begin
      rec_residual <= sum_in;
      rec_length   <= len_cnt;
    end else if (pop && fifo_level > LVL_W'(1)) begin
      rec_residual <= res_mem[rd_ptr_nxt];
      rec_length   <= len_mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      event_count <= '0;
      drop_flag   <= 1'b0;
    end else begin
      if (overflow_in && event_count != 16'hFFFF) event_count <= event_count + 16'd1;
      if (drop)          drop_flag <= 1'b1;
      else if (drop_clr) drop_flag <= 1'b0;
    end
  end

endmodule
